// File: rtl/seq_detect_prog.sv
// Run-time programmable serial bit-pattern detector with per-bit valid qualification,
// overlap/non-overlap restart and a saturating match counter.
module seq_detect_prog #(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 16,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(8'b0000_1100),
  parameter int               LEN_RST = 6
) (
  input  logic             sysClk,
  input  logic             resetAH,
  input  logic             sigA,
  input  logic             sigValid,
  input  logic             overlapMode,
  input  logic             patLoad,
  input  logic [PAT_W-1:0] patIn,
  input  logic [LEN_W-1:0] patLenIn,
  input  logic             cntClr,
  output logic             outAH,
  output logic [CNT_W-1:0] matchCnt,
  output logic             cntSat
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic             newBit;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;

  logic [PAT_W-1:0] lenMask;
  logic             matchC;
  logic [LEN_W-1:0] fillNext;
  logic [LEN_W-1:0] lenLoad;
  logic [CNT_W-1:0] cntNext;

  // Only the low len bits of history and pattern take part in the compare.
  always_comb begin
    lenMask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      lenMask[i] = (LEN_W'(i) < len);
    end
  end

  // newBit gates the compare so a stalled stream cannot re-fire on old history.
  assign matchC = newBit && (len != '0) && (fill >= len) &&
                  (((hist ^ pat) & lenMask) == '0);

  assign lenLoad = (patLenIn > LEN_MAX) ? LEN_MAX : patLenIn;

  always_comb begin
    fillNext = fill;
    if (patLoad) begin
      fillNext = '0;
    end else if (matchC && !overlapMode) begin
      fillNext = sigValid ? LEN_W'(1) : '0;
    end else if (sigValid) begin
      fillNext = (fill >= LEN_MAX) ? LEN_MAX : fill + LEN_W'(1);
    end
  end

  always_comb begin
    cntNext = matchCnt;
    if (matchC) begin
      if (cntClr) begin
        cntNext = CNT_W'(1);
      end else if (matchCnt != CNT_MAX) begin
        cntNext = matchCnt + CNT_W'(1);
      end
    end else if (cntClr) begin
      cntNext = '0;
    end
  end

  always_ff @(posedge sysClk) begin
    if (resetAH) begin
      hist     <= '0;
      fill     <= '0;
      newBit   <= 1'b0;
      pat      <= PAT_RST;
      len      <= LEN_W'(LEN_RST);
      outAH    <= 1'b0;
      matchCnt <= '0;
      cntSat   <= 1'b0;
    end else begin
      if (sigValid && !patLoad) begin
        hist <= {hist[PAT_W-2:0], sigA};
      end
      if (patLoad) begin
        pat <= patIn;
        len <= lenLoad;
      end
      fill     <= fillNext;
      newBit   <= sigValid;
      outAH    <= matchC;
      matchCnt <= cntNext;
      cntSat   <= (cntNext == CNT_MAX);
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: vector table on a default instance plus
// hand-written sequences for pattern-length zero and a 2-bit counter instance.
module tb_seq_detect_prog;

  logic sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  // default-parameter instance
  logic        resetA, sigA, sigValidA, overlapA, patLoadA, cntClrA;
  logic [7:0]  patInA;
  logic [3:0]  patLenA;
  logic        outA, satA;
  logic [15:0] cntA;

  seq_detect_prog dutA (
    .sysClk(sysClk), .resetAH(resetA), .sigA(sigA), .sigValid(sigValidA),
    .overlapMode(overlapA), .patLoad(patLoadA), .patIn(patInA), .patLenIn(patLenA),
    .cntClr(cntClrA), .outAH(outA), .matchCnt(cntA), .cntSat(satA)
  );

  // 2-bit counter instance for saturation
  logic        resetB, sigB, sigValidB, overlapB, patLoadB, cntClrB;
  logic [7:0]  patInB;
  logic [3:0]  patLenB;
  logic        outB, satB;
  logic [1:0]  cntB;

  seq_detect_prog #(.CNT_W(2)) dutB (
    .sysClk(sysClk), .resetAH(resetB), .sigA(sigB), .sigValid(sigValidB),
    .overlapMode(overlapB), .patLoad(patLoadB), .patIn(patInB), .patLenIn(patLenB),
    .cntClr(cntClrB), .outAH(outB), .matchCnt(cntB), .cntSat(satB)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic       a;
    logic       ov;
    logic       ld;
    logic [7:0] pin;
    logic [3:0] plen;
    logic       clr;
    logic       eOut;
    int         eCnt;
  } vec_t;

  vec_t vecs[$];
  int nTests = 0;
  int nFail  = 0;

  function automatic void addV(logic rst, logic vld, logic a, logic ov, logic ld,
                               logic [7:0] pin, logic [3:0] plen, logic eOut, int eCnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.a = a; v.ov = ov; v.ld = ld;
    v.pin = pin; v.plen = plen; v.clr = 1'b0; v.eOut = eOut; v.eCnt = eCnt;
    vecs.push_back(v);
  endfunction

  function automatic void vRst(logic ov);
    addV(1'b1, 1'b1, 1'b0, ov, 1'b0, 8'h00, 4'd0, 1'b0, 0);
  endfunction

  function automatic void vBit(logic a, logic ov, logic eOut, int eCnt);
    addV(1'b0, 1'b1, a, ov, 1'b0, 8'h00, 4'd0, eOut, eCnt);
  endfunction

  function automatic void vIdle(logic ov, logic eOut, int eCnt);
    addV(1'b0, 1'b0, 1'b1, ov, 1'b0, 8'h00, 4'd0, eOut, eCnt);
  endfunction

  // load cycle also presents a '1' bit, which must be dropped
  function automatic void vLoad(logic [7:0] pin, logic [3:0] plen, logic ov,
                                logic eOut, int eCnt);
    addV(1'b0, 1'b1, 1'b1, ov, 1'b1, pin, plen, eOut, eCnt);
  endfunction

  function automatic void vBits(string s, logic ov, int eCnt);
    for (int i = 0; i < s.len(); i++) begin
      vBit(s[i] == "1", ov, 1'b0, eCnt);
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    @(negedge sysClk);
  endtask

  initial begin
    resetA = 1'b1; sigA = 1'b0; sigValidA = 1'b0; overlapA = 1'b1;
    patLoadA = 1'b0; patInA = '0; patLenA = '0; cntClrA = 1'b0;
    resetB = 1'b1; sigB = 1'b0; sigValidB = 1'b0; overlapB = 1'b1;
    patLoadB = 1'b0; patInB = '0; patLenB = '0; cntClrB = 1'b0;

    // default pattern 001100, overlapping: pulses after bits 6 and 10
    vRst(1'b1);
    vBits("001100", 1'b1, 0);
    vBit(1'b1, 1'b1, 1'b1, 1);
    vBits("100", 1'b1, 1);
    vIdle(1'b1, 1'b1, 2);
    vIdle(1'b1, 1'b0, 2);

    // same stream, non-overlapping: single pulse
    vRst(1'b0);
    vBits("001100", 1'b0, 0);
    vBit(1'b1, 1'b0, 1'b1, 1);
    vBits("100", 1'b0, 1);
    vIdle(1'b0, 1'b0, 1);
    vIdle(1'b0, 1'b0, 1);

    // 3-cycle stall mid-pattern, no re-fire while stalled afterwards
    vRst(1'b1);
    vBits("001", 1'b1, 0);
    vIdle(1'b1, 1'b0, 0);
    vIdle(1'b1, 1'b0, 0);
    vIdle(1'b1, 1'b0, 0);
    vBits("100", 1'b1, 0);
    vIdle(1'b1, 1'b1, 1);
    vIdle(1'b1, 1'b0, 1);
    vIdle(1'b1, 1'b0, 1);

    // match pending on a load cycle still reports
    vRst(1'b1);
    vBits("001100", 1'b1, 0);
    vLoad(8'hA5, 4'd8, 1'b1, 1'b1, 1);
    vIdle(1'b1, 1'b0, 1);

    // pattern A5 len 8, overlapping: pulses after bits 8 and 15
    vRst(1'b1);
    vLoad(8'hA5, 4'd8, 1'b1, 1'b0, 0);
    vBits("10100101", 1'b1, 0);
    vBit(1'b0, 1'b1, 1'b1, 1);
    vBits("100101", 1'b1, 1);
    vIdle(1'b1, 1'b1, 2);
    vIdle(1'b1, 1'b0, 2);

    // pattern A5 len 8, non-overlapping: pulse after bit 8 only
    vRst(1'b0);
    vLoad(8'hA5, 4'd8, 1'b0, 1'b0, 0);
    vBits("10100101", 1'b0, 0);
    vBit(1'b0, 1'b0, 1'b1, 1);
    vBits("100101", 1'b0, 1);
    vIdle(1'b0, 1'b0, 1);

    // length 15 clamps to 8
    vRst(1'b1);
    vLoad(8'hA5, 4'd15, 1'b1, 1'b0, 0);
    vBits("10100101", 1'b1, 0);
    vIdle(1'b1, 1'b1, 1);

    // reset after 5 of 6 bits, then the last bit: no pulse
    vRst(1'b1);
    vBits("00110", 1'b1, 0);
    vRst(1'b1);
    vBit(1'b0, 1'b1, 1'b0, 0);
    vIdle(1'b1, 1'b0, 0);
    vIdle(1'b1, 1'b0, 0);

    foreach (vecs[i]) begin
      resetA = vecs[i].rst; sigValidA = vecs[i].vld; sigA = vecs[i].a;
      overlapA = vecs[i].ov; patLoadA = vecs[i].ld; patInA = vecs[i].pin;
      patLenA = vecs[i].plen; cntClrA = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d outAH", i), int'(outA), int'(vecs[i].eOut));
      chk($sformatf("vec%0d matchCnt", i), int'(cntA), vecs[i].eCnt);
      if (vecs[i].rst) chk($sformatf("vec%0d cntSat", i), int'(satA), 0);
    end

    // length zero disables detection over a random stream
    resetA = 1'b1; sigValidA = 1'b0; patLoadA = 1'b0; overlapA = 1'b1;
    tick();
    resetA = 1'b0; patLoadA = 1'b1; patInA = 8'h00; patLenA = 4'd0;
    tick();
    patLoadA = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sigValidA = 1'b1; sigA = 1'($urandom_range(0, 1));
      tick();
      chk($sformatf("len0 bit%0d outAH", i), int'(outA), 0);
    end
    sigValidA = 1'b0;
    tick();
    chk("len0 outAH final", int'(outA), 0);
    chk("len0 matchCnt", int'(cntA), 0);

    // 2-bit counter: eight matches of pattern '1' saturate at 3
    resetB = 1'b1;
    tick();
    chk("B reset matchCnt", int'(cntB), 0);
    chk("B reset cntSat", int'(satB), 0);
    resetB = 1'b0; patLoadB = 1'b1; patInB = 8'h01; patLenB = 4'd1;
    tick();
    patLoadB = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      sigValidB = 1'b1; sigB = 1'b1;
      tick();
      chk($sformatf("B bit%0d matchCnt", j), int'(cntB), (j - 1 > 3) ? 3 : j - 1);
      chk($sformatf("B bit%0d cntSat", j), int'(satB), (j - 1 >= 3) ? 1 : 0);
    end
    // last match still pending while clearing
    sigValidB = 1'b0; cntClrB = 1'b1;
    tick();
    chk("B clr+match matchCnt", int'(cntB), 1);
    chk("B clr+match cntSat", int'(satB), 0);
    chk("B clr+match outAH", int'(outB), 1);
    cntClrB = 1'b0;
    tick();
    chk("B stall matchCnt", int'(cntB), 1);
    chk("B stall outAH", int'(outB), 0);
    cntClrB = 1'b1;
    tick();
    chk("B clr alone matchCnt", int'(cntB), 0);
    cntClrB = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
